// File: rtl/quad_encoder_emulator_pkg.sv
// Shared definitions for the button-driven quadrature encoder emulator:
// phase encodings, channel FSM states, direction and command encodings,
// plus small helpers used to size counters and walk the phase sequence.
package quad_encoder_emulator_pkg;

   // Quadrature phase encodings as {A, B}; incrementing walks 00 -> 01 -> 11 -> 10 -> 00
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      DELAY  = 2'd2,
      REPEAT = 2'd3
   } state_e;

   typedef enum logic {
      INC = 1'b0,
      DEC = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_INC  = 2'd1,
      CMD_DEC  = 2'd2
   } cmd_e;

   // Largest of three cycle parameters; sets the shared counter width
   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter width able to hold values 0 .. max_cyc-1, never below one bit
   function automatic int cnt_width(input int max_cyc);
      return (max_cyc > 2) ? $clog2(max_cyc) : 1;
   endfunction

   // One detent step along the Gray sequence; DEC is the exact reverse of INC
   function automatic logic [1:0] next_phase(input logic [1:0] phase, input dir_e dir);
      logic [1:0] nxt;
      nxt = PH_00;
      if (dir == INC) begin
         case (phase)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
         endcase
      end else begin
         case (phase)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/quad_encoder_emulator_channel.sv
// One player's encoder emulation: 2-flop synchronizer on the Up/Down buttons,
// a debouncer per button, and a step FSM that emits one detent on press and
// auto-repeats while the button stays held. The phase is held on release.
module quad_channel #(
   parameter int DEBOUNCE_CYC     = 1000000,
   parameter int REPEAT_DELAY_CYC = 25000000,
   parameter int STEP_CYC         = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic up_raw,
   input  logic down_raw,
   output logic rot_a,
   output logic rot_b,
   output logic step
);
   import quad_encoder_emulator_pkg::*;

   localparam int CNT_W = cnt_width(max_of3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, STEP_CYC));
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STEP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Bit 0 carries Up, bit 1 carries Down throughout the input path
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            db_q, db_d;
   logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

   state_e           state_q, state_d;
   dir_e             dir_q, dir_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       phase_q, phase_d;
   logic             step_q, step_d;

   cmd_e cmd;
   dir_e cmd_dir;
   logic advance;

   // Two-stage synchronizer feeding the debouncers
   always_comb begin
      sync1_d = {down_raw, up_raw};
      sync2_d = sync1_q;
   end

   // Debounce: flip the accepted level only after DEBOUNCE_CYC consecutive differing samples
   always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] >= DB_LAST) begin
            db_d[i]     = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Both or neither button pressed cancels out to no command
   always_comb begin
      cmd = CMD_NONE;
      if (db_q[0] && !db_q[1]) begin
         cmd = CMD_INC;
      end else if (db_q[1] && !db_q[0]) begin
         cmd = CMD_DEC;
      end
      cmd_dir = (cmd == CMD_DEC) ? DEC : INC;
   end

   // Next-state logic; DELAY expiry itself produces the first auto-repeat step
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (cmd != CMD_NONE) begin
               dir_d   = cmd_dir;
               state_d = FIRST;
            end
         end
         FIRST: begin
            advance = 1'b1;
            timer_d = '0;
            state_d = DELAY;
         end
         DELAY: begin
            if (cmd == CMD_NONE) begin
               timer_d = '0;
               state_d = IDLE;
            end else if (cmd_dir != dir_q) begin
               dir_d   = cmd_dir;
               timer_d = '0;
               state_d = FIRST;
            end else if (timer_q >= RD_LAST) begin
               advance = 1'b1;
               timer_d = '0;
               state_d = REPEAT;
            end else begin
               timer_d = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (cmd == CMD_NONE) begin
               timer_d = '0;
               state_d = IDLE;
            end else if (cmd_dir != dir_q) begin
               dir_d   = cmd_dir;
               timer_d = '0;
               state_d = FIRST;
            end else if (timer_q >= ST_LAST) begin
               advance = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_W'(1);
            end
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: move one detent and pulse step whenever the FSM advances
   always_comb begin
      phase_d = phase_q;
      step_d  = advance;
      if (advance) begin
         phase_d = next_phase(phase_q, dir_q);
      end
   end

   // State register for the synchronizer, debouncers, FSM and phase outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         db_cnt_q <= '0;
         state_q  <= IDLE;
         dir_q    <= INC;
         timer_q  <= '0;
         phase_q  <= PH_00;
         step_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
         state_q  <= state_d;
         dir_q    <= dir_d;
         timer_q  <= timer_d;
         phase_q  <= phase_d;
         step_q   <= step_d;
      end
   end

   assign rot_a = phase_q[1];
   assign rot_b = phase_q[0];
   assign step  = step_q;

endmodule

// File: rtl/quad_encoder_emulator.sv
// Top level: two independent button-to-quadrature channels, one per player,
// presenting the A/B pairs and step pulses the game decoder expects.
module quad_encoder_emulator #(
   parameter int DEBOUNCE_CYC     = 1000000,
   parameter int REPEAT_DELAY_CYC = 25000000,
   parameter int STEP_CYC         = 500000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Up1,
   input  logic Down1,
   input  logic Up2,
   input  logic Down2,
   output logic rota1,
   output logic rotb1,
   output logic rota2,
   output logic rotb2,
   output logic Step1,
   output logic Step2
);
   import quad_encoder_emulator_pkg::*;

   quad_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .STEP_CYC         (STEP_CYC)
   ) u_ch1 (
      .clk      (Clock),
      .rst_n    (Reset),
      .up_raw   (Up1),
      .down_raw (Down1),
      .rot_a    (rota1),
      .rot_b    (rotb1),
      .step     (Step1)
   );

   quad_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .STEP_CYC         (STEP_CYC)
   ) u_ch2 (
      .clk      (Clock),
      .rst_n    (Reset),
      .up_raw   (Up2),
      .down_raw (Down2),
      .rot_a    (rota2),
      .rot_b    (rotb2),
      .step     (Step2)
   );

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator with small cycle parameters.
// With DEBOUNCE_CYC=4 a press driven just after a falling clock edge shows its
// first step 8 rising edges later: 2 synchronizer + 4 debounce + 2 FSM/output.
module tb_quad_encoder_emulator;

   localparam int DB = 4;
   localparam int RD = 40;
   localparam int ST = 8;
   localparam int LAT = 8;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   logic Up1 = 1'b0, Down1 = 1'b0, Up2 = 1'b0, Down2 = 1'b0;
   logic rota1, rotb1, rota2, rotb2, Step1, Step2;

   int compared = 0;
   int failed = 0;

   int cyc = 0;
   int steps1 = 0, steps2 = 0;
   int dec1 = 0, dec2 = 0;
   int anomalies = 0;
   int step1_times[$];
   logic [1:0] prev1 = 2'b00, prev2 = 2'b00;

   typedef struct {
      logic       up1;
      logic       dn1;
      logic       up2;
      logic       dn2;
      int         cycles;
      int         exp_steps1;
      int         exp_steps2;
      logic [1:0] exp_ph1;
      logic [1:0] exp_ph2;
   } vec_t;

   quad_encoder_emulator #(
      .DEBOUNCE_CYC     (DB),
      .REPEAT_DELAY_CYC (RD),
      .STEP_CYC         (ST)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Up1   (Up1),
      .Down1 (Down1),
      .Up2   (Up2),
      .Down2 (Down2),
      .rota1 (rota1),
      .rotb1 (rotb1),
      .rota2 (rota2),
      .rotb2 (rotb2),
      .Step1 (Step1),
      .Step2 (Step2)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   function automatic logic [1:0] inc_of(input logic [1:0] p);
      case (p)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] dec_of(input logic [1:0] p);
      case (p)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Reference decoder: counts steps, tracks direction, flags non-Gray moves or step/phase disagreement
   task automatic observe(input logic [1:0] cur, input logic stp, inout logic [1:0] prev,
                          inout int dec, inout int steps, inout int anom);
      if (stp) steps++;
      if (stp || cur != prev) begin
         if (!stp || cur == prev) begin
            anom++;
            $display("[TB] anomaly at cycle %0d: step=%0b phase %b -> %b", cyc, stp, prev, cur);
         end else if (cur == inc_of(prev)) begin
            dec++;
         end else if (cur == dec_of(prev)) begin
            dec--;
         end else begin
            anom++;
            $display("[TB] anomaly at cycle %0d: non-adjacent phase %b -> %b", cyc, prev, cur);
         end
      end
      prev = cur;
   endtask

   // Sample just after each rising edge; a reset returns the model phase to 00
   always @(posedge Clock) begin
      #1;
      if (!Reset) begin
         prev1 = 2'b00;
         prev2 = 2'b00;
      end else begin
         if (Step1) step1_times.push_back(cyc);
         observe({rota1, rotb1}, Step1, prev1, dec1, steps1, anomalies);
         observe({rota2, rotb2}, Step2, prev2, dec2, steps2, anomalies);
      end
   end

   task automatic applyStimulus(input logic u1, input logic d1, input logic u2, input logic d2,
                                input int cycles);
      Up1   = u1;
      Down1 = d1;
      Up2   = u2;
      Down2 = d2;
      repeat (cycles) @(negedge Clock);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int last_step1();
      if (step1_times.size() == 0) return -1;
      return step1_times[step1_times.size()-1];
   endfunction

   initial begin
      vec_t vecs [0:10];
      int   row_start [0:10];
      int   s1, s2, k, m, r;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 200, 0, 0, 2'b00, 2'b00};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  30, 1, 0, 2'b01, 2'b00};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2'b01, 2'b00};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  80, 6, 0, 2'b10, 2'b00};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2'b10, 2'b00};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1,  64, 0, 4, 2'b10, 2'b00};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2'b10, 2'b00};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0,  10, 1, 1, 2'b00, 2'b01};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2'b00, 2'b01};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  60, 0, 0, 2'b00, 2'b01};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2'b00, 2'b01};

      // Reset state
      repeat (5) @(negedge Clock);
      checkOutput("reset_rota1", int'(rota1), 0);
      checkOutput("reset_rotb1", int'(rotb1), 0);
      checkOutput("reset_rota2", int'(rota2), 0);
      checkOutput("reset_rotb2", int'(rotb2), 0);
      checkOutput("reset_step1", int'(Step1), 0);
      checkOutput("reset_step2", int'(Step2), 0);
      Reset = 1'b1;

      // Table-driven rows: hold inputs for a number of cycles, then check step counts and phases
      for (int i = 0; i <= 10; i++) begin
         s1 = steps1;
         s2 = steps2;
         row_start[i] = cyc;
         applyStimulus(vecs[i].up1, vecs[i].dn1, vecs[i].up2, vecs[i].dn2, vecs[i].cycles);
         checkOutput($sformatf("row%0d_steps1", i), steps1 - s1, vecs[i].exp_steps1);
         checkOutput($sformatf("row%0d_steps2", i), steps2 - s2, vecs[i].exp_steps2);
         checkOutput($sformatf("row%0d_phase1", i), int'({rota1, rotb1}), int'(vecs[i].exp_ph1));
         checkOutput($sformatf("row%0d_phase2", i), int'({rota2, rotb2}), int'(vecs[i].exp_ph2));
      end

      // Latency and auto-repeat spacing from the recorded step times
      checkOutput("step1_total", step1_times.size(), 8);
      if (step1_times.size() >= 8) begin
         checkOutput("latency_row1", step1_times[0] - row_start[1], LAT);
         checkOutput("latency_row3", step1_times[1] - row_start[3], LAT);
         checkOutput("repeat_delay", step1_times[2] - step1_times[1], RD);
         for (int j = 3; j <= 6; j++)
            checkOutput($sformatf("repeat_step%0d", j), step1_times[j] - step1_times[j-1], ST);
         checkOutput("latency_row7", step1_times[7] - row_start[7], LAT);
      end
      checkOutput("decoder1_table", dec1, 8);
      checkOutput("decoder2_table", dec2, -3);

      // Direction reversal while auto-repeating goes straight back to FIRST
      s1 = steps1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 48);
      checkOutput("rev_up_steps", steps1 - s1, 2);
      checkOutput("rev_up_phase", int'({rota1, rotb1}), 3);
      m = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10);
      checkOutput("rev_steps", steps1 - s1, 3);
      checkOutput("rev_step_time", last_step1() - m, LAT);
      checkOutput("rev_phase", int'({rota1, rotb1}), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);
      checkOutput("rev_release_steps", steps1 - s1, 3);

      // Bouncing button: no step until the level is stable for DB cycles
      s1 = steps1;
      for (int i = 0; i < 10; i++)
         applyStimulus((i % 2) == 0, 1'b0, 1'b0, 1'b0, 2);
      checkOutput("bounce_no_step", steps1 - s1, 0);
      k = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
      checkOutput("bounce_steps", steps1 - s1, 1);
      checkOutput("bounce_latency", last_step1() - k, LAT);
      checkOutput("bounce_phase", int'({rota1, rotb1}), 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);

      // Reset asserted in REPEAT on the cycle the phase reaches 11
      s1 = steps1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64);
      checkOutput("pre_reset_steps", steps1 - s1, 4);
      checkOutput("pre_reset_phase", int'({rota1, rotb1}), 3);
      checkOutput("pre_reset_step1", int'(Step1), 1);
      s1 = steps1;
      #2 Reset = 1'b0;
      #1;
      checkOutput("async_reset_rota1", int'(rota1), 0);
      checkOutput("async_reset_rotb1", int'(rotb1), 0);
      checkOutput("async_reset_step1", int'(Step1), 0);
      checkOutput("async_reset_phase2", int'({rota2, rotb2}), 0);
      repeat (3) @(negedge Clock);
      checkOutput("held_reset_phase1", int'({rota1, rotb1}), 0);
      checkOutput("held_reset_steps", steps1 - s1, 0);
      Reset = 1'b1;
      r = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
      checkOutput("post_reset_steps", steps1 - s1, 1);
      checkOutput("post_reset_latency", last_step1() - r, LAT);
      checkOutput("post_reset_phase", int'({rota1, rotb1}), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);

      checkOutput("decoder1_final", dec1, 15);
      checkOutput("decoder2_final", dec2, -3);
      checkOutput("monitor_anomalies", anomalies, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
